// File: rtl/text_frame_pkg.sv
// Shared constants and FSM state type for the AXI4-Stream text framer.
package text_frame_pkg;
    localparam int TXT_ROWS   = 4;
    localparam int TXT_COLS   = 16;
    localparam int TXT_CHAR_W = 8;
    localparam int TXT_ROW_W  = TXT_COLS * TXT_CHAR_W;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;
endpackage

// File: rtl/axis_text_row.sv
// One 16-character back-buffer row: single byte-lane write or full-row fill.
module axis_text_row
    import text_frame_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [3:0]            col,
    input  logic [TXT_CHAR_W-1:0] data,
    output logic [TXT_ROW_W-1:0]  row
);
    // Column 0 occupies the most significant byte lane.
    always_ff @(posedge clk) begin
        if (clr) begin
            row <= {TXT_COLS{FILL_CHAR}};
        end else if (we) begin
            row[TXT_CHAR_W*int'(4'd15 - col) +: TXT_CHAR_W] <= data;
        end
    end
endmodule

// File: rtl/axis_text_framer.sv
// AXI4-Stream byte sink that assembles a 4x16 text frame and publishes it atomically on tlast.
// Optional macro AXIS_TEXT_CTRL_EN: LF/CR in the stream move the write cursor instead of being stored.
module axis_text_framer
    import text_frame_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR   = 8'h20,
    parameter int         HOLD_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [TXT_ROW_W-1:0] str1,
    output logic [TXT_ROW_W-1:0] str2,
    output logic [TXT_ROW_W-1:0] str3,
    output logic [TXT_ROW_W-1:0] str4,
    output logic                 frame_done,
    output logic                 frame_ovf,
    output logic [15:0]          frame_count
);
    state_t               state, state_next;
    logic [1:0]           clr_idx;
    logic [6:0]           ptr;      // linear cell index; bit 6 set means the frame is full
    logic                 ovf_acc;
    logic [15:0]          hold_cnt;
    logic                 beat, is_lf, is_cr, store, drop;
    logic [TXT_ROWS-1:0]  row_we, row_clr;
    logic [TXT_ROW_W-1:0] back [TXT_ROWS];

    assign beat = s_axis_tvalid && s_axis_tready;
`ifdef AXIS_TEXT_CTRL_EN
    assign is_lf = (s_axis_tdata == ASCII_LF);
    assign is_cr = (s_axis_tdata == ASCII_CR);
`else
    assign is_lf = 1'b0;
    assign is_cr = 1'b0;
`endif
    assign store = beat && !is_lf && !is_cr && !ptr[6];
    assign drop  = beat && !is_lf && !is_cr && ptr[6];

    for (genvar g = 0; g < TXT_ROWS; g++) begin : g_row
        assign row_we[g]  = store && (ptr[5:4] == 2'(g));
        assign row_clr[g] = (state == ST_CLEAR) && (clr_idx == 2'(g));
        axis_text_row #(.FILL_CHAR(FILL_CHAR)) u_row (
            .clk  (clk),
            .clr  (row_clr[g]),
            .we   (row_we[g]),
            .col  (ptr[3:0]),
            .data (s_axis_tdata),
            .row  (back[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        s_axis_tready = 1'b0;
        case (state)
            ST_CLEAR:  if (clr_idx == 2'd3) state_next = ST_RECV;
            ST_RECV: begin
                s_axis_tready = 1'b1;
                if (beat && s_axis_tlast) state_next = ST_COMMIT;
            end
            ST_COMMIT: state_next = (HOLD_CYCLES > 0) ? ST_HOLD : ST_CLEAR;
            ST_HOLD:   if (hold_cnt == 16'(HOLD_CYCLES - 1)) state_next = ST_CLEAR;
            default:   state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx  <= 2'd0;
            ptr      <= 7'd0;
            ovf_acc  <= 1'b0;
            hold_cnt <= 16'd0;
        end else begin
            clr_idx  <= (state == ST_CLEAR) ? clr_idx + 2'd1 : 2'd0;
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + 16'd1 : 16'd0;
            if (state == ST_CLEAR) begin
                ptr     <= 7'd0;
                ovf_acc <= 1'b0;
            end else if (beat) begin
                // LF past the last row parks the cursor in the overflow region
                if (is_lf) begin
                    if (!ptr[6]) ptr <= {ptr[6:4] + 3'd1, 4'd0};
                end else if (is_cr) begin
                    ptr <= {ptr[6:4], 4'd0};
                end else if (!ptr[6]) begin
                    ptr <= ptr + 7'd1;
                end
                if (drop) ovf_acc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            str1        <= {TXT_COLS{FILL_CHAR}};
            str2        <= {TXT_COLS{FILL_CHAR}};
            str3        <= {TXT_COLS{FILL_CHAR}};
            str4        <= {TXT_COLS{FILL_CHAR}};
            frame_done  <= 1'b0;
            frame_ovf   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            frame_done <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                str1        <= back[0];
                str2        <= back[1];
                str3        <= back[2];
                str4        <= back[3];
                frame_ovf   <= ovf_acc;
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_text_framer.sv
// Self-checking bench for axis_text_framer: directed and random frames against a cursor-based frame model.
module tb_axis_text_framer;
    localparam int         HOLD = 3;
    localparam logic [7:0] FILL = 8'h20;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   tdata;
    logic         tvalid, tready, tlast;
    logic [127:0] str1, str2, str3, str4;
    logic         frame_done, frame_ovf;
    logic [15:0]  frame_count;

    int checks = 0;
    int errors = 0;

    logic [127:0] pub [4];
    logic         pub_ovf;
    int           exp_count;
    logic [127:0] mdl_rows [4];
    logic         mdl_ovf;

    axis_text_framer #(.FILL_CHAR(FILL), .HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .str1          (str1),
        .str2          (str2),
        .str3          (str3),
        .str4          (str4),
        .frame_done    (frame_done),
        .frame_ovf     (frame_ovf),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected frame from the byte list: a text cursor walking a 64-cell grid.
    function automatic void model(input logic [7:0] q[$]);
        logic [7:0] cells [64];
        int r, c;
        for (int k = 0; k < 64; k++) cells[k] = FILL;
        r = 0; c = 0; mdl_ovf = 1'b0;
        foreach (q[i]) begin
`ifdef AXIS_TEXT_CTRL_EN
            if (q[i] == 8'h0A) begin
                if (r < 4) begin r++; c = 0; end
                continue;
            end
            if (q[i] == 8'h0D) begin c = 0; continue; end
`endif
            if (r < 4) begin
                cells[r*16 + c] = q[i];
                c++;
                if (c == 16) begin c = 0; r++; end
            end else begin
                mdl_ovf = 1'b1;
            end
        end
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 16; cc++)
                mdl_rows[rr][127 - 8*cc -: 8] = cells[rr*16 + cc];
    endfunction

    task automatic check_held(input string tag);
        chk({tag, "_str1"}, str1, pub[0]);
        chk({tag, "_str2"}, str2, pub[1]);
        chk({tag, "_str3"}, str3, pub[2]);
        chk({tag, "_str4"}, str4, pub[3]);
        chk({tag, "_ovf"}, frame_ovf, pub_ovf);
        chk({tag, "_count"}, frame_count, exp_count[15:0]);
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int gap_pct, input bit junk_after);
        int  i = 0;
        int  stall = 0;
        int  low;
        logic acc;
        model(q);
        while (i < q.size()) begin
            @(negedge clk);
            chk("idle_done", frame_done, 1'b0);
            check_held("hold");
            if ($urandom_range(99) < gap_pct) begin
                tvalid = 1'b0; tdata = 8'($urandom); tlast = 1'($urandom);
            end else begin
                tvalid = 1'b1; tdata = q[i]; tlast = (i == q.size() - 1);
            end
            acc = tvalid && tready;
            if (!acc) stall++;
            if (stall > 300) begin
                chk("beat_timeout", 1'b0, 1'b1);
                tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            if (acc) i++;
        end
        @(negedge clk);
        tvalid = junk_after; tdata = 8'($urandom); tlast = 1'($urandom);
        chk("commit_cycle_done", frame_done, 1'b0);
        chk("commit_cycle_ready", tready, 1'b0);
        @(negedge clk);
        for (int r = 0; r < 4; r++) pub[r] = mdl_rows[r];
        pub_ovf = mdl_ovf;
        exp_count++;
        chk("done_pulse", frame_done, 1'b1);
        check_held("publish");
        low = 1;
        while (!tready && low < 60) begin
            low++;
            @(negedge clk);
            tdata = 8'($urandom); tlast = 1'($urandom);
            chk("post_done", frame_done, 1'b0);
            check_held("post");
        end
        tvalid = 1'b0;
        chk("ready_low_cycles", 128'(low), 128'(5 + HOLD));
    endtask

    logic [7:0] q [$];

    initial begin
        rst = 1'b1; tvalid = 1'b0; tdata = 8'h00; tlast = 1'b0;
        for (int r = 0; r < 4; r++) pub[r] = {16{FILL}};
        pub_ovf = 1'b0; exp_count = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", tready, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        check_held("rst");
        rst = 1'b0;

        // "HELLO"
        q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        send_frame(q, 0, 1'b0);
        chk("hello_str1", str1, {40'h48454C4C4F, {11{8'h20}}});
        chk("hello_str4", str4, {16{8'h20}});
        chk("hello_count", frame_count, 16'd1);

        // exactly 64 bytes, then 70 bytes
        q = {};
        for (int k = 0; k < 64; k++) q.push_back(8'(8'h41 + k));
        send_frame(q, 0, 1'b0);
        chk("full_first", str1[127:120], 8'h41);
        chk("full_last", str4[7:0], 8'h80);
        chk("full_ovf", frame_ovf, 1'b0);
        q = {};
        for (int k = 0; k < 70; k++) q.push_back(8'(8'h41 + k));
        send_frame(q, 20, 1'b1);
        chk("over_ovf", frame_ovf, 1'b1);
        chk("over_last", str4[7:0], 8'h80);

        // control characters
        q = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h44, 8'h0D, 8'h58};
        send_frame(q, 0, 1'b0);
`ifdef AXIS_TEXT_CTRL_EN
        chk("ctrl_str1", str1, {16'h4142, {14{8'h20}}});
        chk("ctrl_str2", str2, {16'h5844, {14{8'h20}}});
`else
        chk("ctrl_str1", str1, {56'h41420A43440D58, {9{8'h20}}});
`endif

        // back-to-back frames with junk offered during the dead time
        for (int f = 0; f < 2; f++) begin
            q = {};
            for (int k = 0; k < 20 + 10*f; k++) q.push_back(8'($urandom_range(8'h21, 8'h7E)));
            send_frame(q, 0, 1'b1);
        end

        // random frames
        for (int f = 0; f < 8; f++) begin
            q = {};
            for (int k = 0; k < int'($urandom_range(1, 80)); k++) begin
                if ($urandom_range(9) == 0) q.push_back($urandom_range(1) ? 8'h0A : 8'h0D);
                else q.push_back(8'($urandom_range(8'h20, 8'h7E)));
            end
            send_frame(q, 30, 1'($urandom));
        end

        // reset after 10 bytes of an unterminated frame
        begin
            int got = 0;
            int guard = 0;
            while (got < 10 && guard < 100) begin
                @(negedge clk);
                tvalid = 1'b1; tdata = 8'($urandom_range(8'h21, 8'h7E)); tlast = 1'b0;
                guard++;
                if (tready) got++;
                @(posedge clk);
            end
            chk("partial_beats", 128'(got), 128'd10);
        end
        @(negedge clk);
        chk("partial_no_commit", frame_done, 1'b0);
        tvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) pub[r] = {16{FILL}};
        pub_ovf = 1'b0; exp_count = 0;
        chk("midrst_done", frame_done, 1'b0);
        chk("midrst_ready", tready, 1'b0);
        check_held("midrst");
        rst = 1'b0;
        q = '{8'h4F, 8'h4B};
        send_frame(q, 10, 1'b0);
        chk("after_rst_str1", str1, {16'h4F4B, {14{8'h20}}});
        chk("after_rst_count", frame_count, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
